// File: rtl/err_monitor_if.sv
// err_monitor_if: mismatch inputs, phase-select feedback and windowed error outputs of the MEDAC error monitor.
interface err_monitor_if;
    logic       en;
    logic       mis_leading;
    logic       mis_origin;
    logic       mis_lagging;
    logic [1:0] clk_sel;
    logic       error_leading;
    logic       error_origin;
    logic       error_lagging;
    logic       win_done;
    logic [7:0] err_cnt_total;
    modport master (
        output en, mis_leading, mis_origin, mis_lagging, clk_sel,
        input  error_leading, error_origin, error_lagging, win_done, err_cnt_total
    );
    modport slave (
        input  en, mis_leading, mis_origin, mis_lagging, clk_sel,
        output error_leading, error_origin, error_lagging, win_done, err_cnt_total
    );
endinterface

// File: rtl/err_monitor.sv
// err_monitor: windowed, thresholded per-path mismatch monitor with hold-off blanking after enable or clk_sel change.
module err_monitor #(
    parameter int WIN     = 64,
    parameter int CNT_W   = 7,
    parameter int THRESH  = 4,
    parameter int HOLDOFF = 8
) (
    input logic         clk,
    input logic         rst_n,
    err_monitor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HOLD, COUNT} state_t;
    localparam logic [CNT_W-1:0] TH = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] WL = CNT_W'(WIN - 1);
    localparam logic [CNT_W-1:0] HL = CNT_W'(HOLDOFF - 1);
    state_t           state;
    logic [1:0]       sel_q;
    logic [CNT_W-1:0] hold_cnt, win_cnt, cnt_ld, cnt_or, cnt_lg;
    logic [CNT_W-1:0] nxt_ld, nxt_or, nxt_lg;
    logic             hit_ld, hit_or, hit_lg, sel_chg, win_end;
    // Path counters saturate at THRESH so a narrow counter never wraps back below it.
    always_comb begin
        sel_chg = bus.clk_sel != sel_q;
        win_end = win_cnt == WL;
        nxt_ld  = cnt_ld + CNT_W'(bus.mis_leading && cnt_ld < TH);
        nxt_or  = cnt_or + CNT_W'(bus.mis_origin && cnt_or < TH);
        nxt_lg  = cnt_lg + CNT_W'(bus.mis_lagging && cnt_lg < TH);
        hit_ld  = nxt_ld >= TH;
        hit_or  = nxt_or >= TH;
        hit_lg  = nxt_lg >= TH;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            sel_q             <= 2'b01;
            hold_cnt          <= '0;
            win_cnt           <= '0;
            cnt_ld            <= '0;
            cnt_or            <= '0;
            cnt_lg            <= '0;
            bus.error_leading <= 1'b0;
            bus.error_origin  <= 1'b0;
            bus.error_lagging <= 1'b0;
            bus.win_done      <= 1'b0;
            bus.err_cnt_total <= '0;
        end else begin
            sel_q             <= bus.clk_sel;
            bus.error_leading <= 1'b0;
            bus.error_origin  <= 1'b0;
            bus.error_lagging <= 1'b0;
            bus.win_done      <= 1'b0;
            hold_cnt          <= '0;
            win_cnt           <= '0;
            cnt_ld            <= '0;
            cnt_or            <= '0;
            cnt_lg            <= '0;
            // Disable outranks a phase change; a phase change outranks a window close.
            if (!bus.en) begin
                state <= IDLE;
            end else if (state == IDLE || sel_chg) begin
                state <= HOLD;
            end else if (state == HOLD) begin
                state    <= hold_cnt == HL ? COUNT : HOLD;
                hold_cnt <= hold_cnt == HL ? '0 : hold_cnt + 1'b1;
            end else if (win_end) begin
                bus.error_leading <= hit_ld;
                bus.error_origin  <= hit_or;
                bus.error_lagging <= hit_lg;
                bus.win_done      <= 1'b1;
                if ((hit_ld || hit_or || hit_lg) && bus.err_cnt_total != 8'hFF)
                    bus.err_cnt_total <= bus.err_cnt_total + 8'd1;
            end else begin
                win_cnt <= win_cnt + 1'b1;
                cnt_ld  <= nxt_ld;
                cnt_or  <= nxt_or;
                cnt_lg  <= nxt_lg;
            end
        end
    end
endmodule

// File: tb/tb_err_monitor.sv
// tb_err_monitor: directed checks of window timing, thresholds, hold-off, enable, reset and saturation.
module tb_err_monitor;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    logic [3:0] o;
    err_monitor_if bus();
    err_monitor dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    assign o = {bus.error_leading, bus.error_origin, bus.error_lagging, bus.win_done};

    task automatic run_win(input int n_ld, input int n_or, input int n_lg, input int off);
        for (int i = 0; i < 64; i++) begin
            bus.mis_leading = i >= off && i < off + n_ld;
            bus.mis_origin  = i >= off && i < off + n_or;
            bus.mis_lagging = i >= off && i < off + n_lg;
            @(negedge clk);
        end
        bus.mis_leading = 1'b0;
        bus.mis_origin  = 1'b0;
        bus.mis_lagging = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.mis_leading = 1'b0;
        bus.mis_origin = 1'b0;
        bus.mis_lagging = 1'b0;
        bus.clk_sel = 2'b01;
        repeat (2) @(negedge clk);
        tests++;
        if (o !== 4'b0000) begin fails++; $display("FAIL reset_flags: got %b expected 0000", o); end
        tests++;
        if (bus.err_cnt_total !== 8'd0) begin fails++; $display("FAIL reset_total: got %0d expected 0", bus.err_cnt_total); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (o !== 4'b0000) begin fails++; $display("FAIL idle_flags: got %b expected 0000", o); end
    endtask

    task automatic test_quiet;
        logic bad = 1'b0;
        bus.en = 1'b1;
        repeat (72) begin
            @(negedge clk);
            if (o !== 4'b0000) bad = 1'b1;
        end
        tests++;
        if (bad) begin fails++; $display("FAIL first_latency_early: got a pulse before cycle 73 expected none"); end
        @(negedge clk);
        tests++;
        if (o !== 4'b0001) begin fails++; $display("FAIL first_win_done: got %b expected 0001", o); end
        bad = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (i < 63 && o !== 4'b0000) bad = 1'b1;
        end
        tests++;
        if (bad) begin fails++; $display("FAIL quiet_gap: got a pulse inside window expected none"); end
        tests++;
        if (o !== 4'b0001 || bus.err_cnt_total !== 8'd0) begin
            fails++; $display("FAIL second_win_done: got %b total %0d expected 0001 total 0", o, bus.err_cnt_total);
        end
    endtask

    task automatic test_thresh;
        run_win(0, 0, 4, 60);
        tests++;
        if (o !== 4'b0011 || bus.err_cnt_total !== 8'd1) begin
            fails++; $display("FAIL lag_4: got %b total %0d expected 0011 total 1", o, bus.err_cnt_total);
        end
        run_win(0, 0, 3, 61);
        tests++;
        if (o !== 4'b0001 || bus.err_cnt_total !== 8'd1) begin
            fails++; $display("FAIL lag_3: got %b total %0d expected 0001 total 1", o, bus.err_cnt_total);
        end
    endtask

    task automatic test_multi;
        run_win(10, 10, 0, 5);
        tests++;
        if (o !== 4'b1101 || bus.err_cnt_total !== 8'd2) begin
            fails++; $display("FAIL lead_origin: got %b total %0d expected 1101 total 2", o, bus.err_cnt_total);
        end
    endtask

    task automatic test_phase;
        logic bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.mis_origin = i < 10;
            @(negedge clk);
        end
        bus.mis_origin = 1'b0;
        bus.clk_sel = 2'b10;
        repeat (72) begin
            @(negedge clk);
            if (o !== 4'b0000) bad = 1'b1;
        end
        tests++;
        if (bad) begin fails++; $display("FAIL phase_blank: got a pulse within 72 cycles of change expected none"); end
        @(negedge clk);
        tests++;
        if (o !== 4'b0001 || bus.err_cnt_total !== 8'd2) begin
            fails++; $display("FAIL phase_resume: got %b total %0d expected 0001 total 2", o, bus.err_cnt_total);
        end
        for (int i = 0; i < 63; i++) begin
            bus.mis_origin = i < 10;
            @(negedge clk);
        end
        bus.mis_origin = 1'b0;
        bus.clk_sel = 2'b01;
        @(negedge clk);
        tests++;
        if (o !== 4'b0000) begin fails++; $display("FAIL close_change: got %b expected 0000", o); end
        repeat (72) @(negedge clk);
        tests++;
        if (o !== 4'b0001 || bus.err_cnt_total !== 8'd2) begin
            fails++; $display("FAIL close_change_resume: got %b total %0d expected 0001 total 2", o, bus.err_cnt_total);
        end
    endtask

    task automatic test_enable;
        logic bad = 1'b0;
        bus.en = 1'b0;
        @(negedge clk);
        bus.en = 1'b1;
        bus.mis_leading = 1'b1;
        bus.mis_origin = 1'b1;
        bus.mis_lagging = 1'b1;
        repeat (9) @(negedge clk);
        bus.mis_leading = 1'b0;
        bus.mis_origin = 1'b0;
        bus.mis_lagging = 1'b0;
        repeat (64) @(negedge clk);
        tests++;
        if (o !== 4'b0001 || bus.err_cnt_total !== 8'd2) begin
            fails++; $display("FAIL holdoff_ignore: got %b total %0d expected 0001 total 2", o, bus.err_cnt_total);
        end
        bus.mis_lagging = 1'b1;
        repeat (30) @(negedge clk);
        bus.mis_lagging = 1'b0;
        bus.en = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (o !== 4'b0000) bad = 1'b1;
        end
        tests++;
        if (bad || bus.err_cnt_total !== 8'd2) begin
            fails++; $display("FAIL en_drop: got pulse=%0d total %0d expected pulse=0 total 2", bad, bus.err_cnt_total);
        end
    endtask

    task automatic test_reset_sat;
        logic bad = 1'b0;
        bus.en = 1'b1;
        repeat (73) @(negedge clk);
        tests++;
        if (o !== 4'b0001) begin fails++; $display("FAIL reenable: got %b expected 0001", o); end
        bus.mis_leading = 1'b1;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (o !== 4'b0000 || bus.err_cnt_total !== 8'd0) begin
            fails++; $display("FAIL async_reset: got %b total %0d expected 0000 total 0", o, bus.err_cnt_total);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (72) begin
            @(negedge clk);
            if (o !== 4'b0000) bad = 1'b1;
        end
        tests++;
        if (bad) begin fails++; $display("FAIL partial_window: got a pulse after reset release expected none"); end
        @(negedge clk);
        tests++;
        if (o !== 4'b1001 || bus.err_cnt_total !== 8'd1) begin
            fails++; $display("FAIL post_reset_win: got %b total %0d expected 1001 total 1", o, bus.err_cnt_total);
        end
        repeat (254 * 64) @(negedge clk);
        tests++;
        if (bus.err_cnt_total !== 8'd255) begin fails++; $display("FAIL total_255: got %0d expected 255", bus.err_cnt_total); end
        repeat (64) @(negedge clk);
        tests++;
        if (o !== 4'b1001 || bus.err_cnt_total !== 8'd255) begin
            fails++; $display("FAIL total_sat: got %b total %0d expected 1001 total 255", o, bus.err_cnt_total);
        end
    endtask

    initial begin
        test_reset;
        test_quiet;
        test_thresh;
        test_multi;
        test_phase;
        test_enable;
        test_reset_sat;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
